// File: rtl/cache_line_bank_if.sv
// cache_line_bank_if: bus between the cache controller / CPU read port
// (master) and the banked line store (slave).
//   REQ/WE/BURST/ADDR/DI : request and fill-beat channel (master -> slave)
//   READY                : slave can take a request or fill beat
//   DO/DO_OFFSET/DO_VALID/DO_LAST : registered read word stream (slave -> master)
//   DO_READY             : consumer backpressure (master -> slave)
interface cache_line_bank_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int WORDS_PER_LINE  = 8,
    parameter int LINE_ADDR_WIDTH = 11
);
    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int ADDR_W   = LINE_ADDR_WIDTH + OFFSET_W;

    logic                  REQ;
    logic                  WE;
    logic                  BURST;
    logic [ADDR_W-1:0]     ADDR;
    logic [DATA_WIDTH-1:0] DI;
    logic                  READY;
    logic [DATA_WIDTH-1:0] DO;
    logic [OFFSET_W-1:0]   DO_OFFSET;
    logic                  DO_VALID;
    logic                  DO_LAST;
    logic                  DO_READY;

    modport master (
        output REQ, WE, BURST, ADDR, DI, DO_READY,
        input  READY, DO, DO_OFFSET, DO_VALID, DO_LAST
    );

    modport slave (
        input  REQ, WE, BURST, ADDR, DI, DO_READY,
        output READY, DO, DO_OFFSET, DO_VALID, DO_LAST
    );
endinterface

// File: rtl/cache_line_bank.sv
// cache_line_bank: banked cache line data store. One synchronous RAM bank per
// word of a line so a full line is read in one access; reads stream out
// critical word first, wrapping within the line; fills arrive one word per
// beat starting at the same offset.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : cache_line_bank_if.slave (request, fill and read stream)

// One bank: single-port synchronous RAM, registered read data.
module cache_line_bank_ram #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          CLK,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Contents are intentionally never reset.
    always_ff @(posedge CLK) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

module cache_line_bank #(
    parameter int DATA_WIDTH      = 8,
    parameter int WORDS_PER_LINE  = 8,   // power of two, >= 2
    parameter int LINE_ADDR_WIDTH = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    cache_line_bank_if.slave  bus
);
    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int ADDR_W   = LINE_ADDR_WIDTH + OFFSET_W;
    localparam logic [OFFSET_W:0] CNT_ONE  = (OFFSET_W+1)'(1);
    localparam logic [OFFSET_W:0] CNT_LAST = (OFFSET_W+1)'(WORDS_PER_LINE - 1);
    localparam logic [OFFSET_W:0] CNT_FULL = (OFFSET_W+1)'(WORDS_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_STREAM, S_FILL} state_e;

    state_e                     state_q, state_d;
    logic [OFFSET_W-1:0]        start_q, start_d;
    logic [LINE_ADDR_WIDTH-1:0] line_q, line_d;
    logic                       burst_q, burst_d;
    logic [OFFSET_W:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      do_q, do_d;
    logic [OFFSET_W-1:0]        do_off_q, do_off_d;
    logic                       do_vld_q, do_vld_d;
    logic                       do_last_q, do_last_d;

    logic [WORDS_PER_LINE-1:0]                 bank_en, bank_we;
    logic [LINE_ADDR_WIDTH-1:0]                bank_addr;
    logic [DATA_WIDTH-1:0]                     bank_wdata;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_reg_q;
    logic                                      line_ld;

    logic [OFFSET_W-1:0]        req_off;
    logic [LINE_ADDR_WIDTH-1:0] req_line;
    logic [OFFSET_W-1:0]        wrap_idx;

    assign req_off  = bus.ADDR[OFFSET_W-1:0];
    assign req_line = bus.ADDR[ADDR_W-1:OFFSET_W];
    // Truncation to OFFSET_W bits gives the wrap within the line.
    assign wrap_idx = start_q + cnt_q[OFFSET_W-1:0];

    for (genvar b = 0; b < WORDS_PER_LINE; b++) begin : g_bank
        cache_line_bank_ram #(
            .DW (DATA_WIDTH),
            .AW (LINE_ADDR_WIDTH)
        ) u_ram (
            .CLK     (CLK),
            .en_i    (bank_en[b]),
            .we_i    (bank_we[b]),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        line_d     = line_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        do_d       = do_q;
        do_off_d   = do_off_q;
        do_vld_d   = do_vld_q;
        do_last_d  = do_last_q;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = req_line;
        bank_wdata = bus.DI;
        line_ld    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    start_d = req_off;
                    line_d  = req_line;
                    if (bus.WE) begin
                        bank_en[req_off] = 1'b1;
                        bank_we[req_off] = 1'b1;
                        if (bus.BURST) begin
                            cnt_d   = CNT_ONE;
                            state_d = S_FILL;
                        end
                    end else begin
                        if (bus.BURST) bank_en = '1;
                        else           bank_en[req_off] = 1'b1;
                        burst_d = bus.BURST;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // RAM outputs are valid now; first word comes straight from the bank.
                line_ld   = 1'b1;
                do_d      = bank_rdata[start_q];
                do_off_d  = start_q;
                do_vld_d  = 1'b1;
                do_last_d = !burst_q;
                cnt_d     = CNT_ONE;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (do_vld_q && bus.DO_READY) begin
                    if (do_last_q) begin
                        do_vld_d  = 1'b0;
                        do_last_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        do_d      = line_reg_q[wrap_idx];
                        do_off_d  = wrap_idx;
                        cnt_d     = cnt_q + 1'b1;
                        do_last_d = ((cnt_q + 1'b1) == CNT_FULL);
                    end
                end
            end
            S_FILL: begin
                bank_addr = line_q;
                if (bus.REQ) begin
                    bank_en[wrap_idx] = 1'b1;
                    bank_we[wrap_idx] = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            line_q    <= '0;
            burst_q   <= 1'b0;
            cnt_q     <= '0;
            do_q      <= '0;
            do_off_q  <= '0;
            do_vld_q  <= 1'b0;
            do_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            line_q    <= line_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            do_q      <= do_d;
            do_off_q  <= do_off_d;
            do_vld_q  <= do_vld_d;
            do_last_q <= do_last_d;
        end
    end

    // Line buffer is plain data; it is only consumed after a load.
    always_ff @(posedge CLK) begin
        if (line_ld) line_reg_q <= bank_rdata;
    end

    assign bus.READY     = (state_q == S_IDLE) || (state_q == S_FILL);
    assign bus.DO        = do_q;
    assign bus.DO_OFFSET = do_off_q;
    assign bus.DO_VALID  = do_vld_q;
    assign bus.DO_LAST   = do_last_q;
endmodule

// File: tb/tb_cache_line_bank.sv
// tb_cache_line_bank: directed bench for cache_line_bank. Exercises the
// default 8x8-bit configuration and a 4x32-bit configuration side by side.
module tb_cache_line_bank;
    logic CLK;
    logic RST_N;
    int   n_cmp = 0;
    int   n_err = 0;

    cache_line_bank_if #(.DATA_WIDTH(8),  .WORDS_PER_LINE(8), .LINE_ADDR_WIDTH(11)) b8 ();
    cache_line_bank_if #(.DATA_WIDTH(32), .WORDS_PER_LINE(4), .LINE_ADDR_WIDTH(11)) b4 ();

    cache_line_bank #(.DATA_WIDTH(8),  .WORDS_PER_LINE(8), .LINE_ADDR_WIDTH(11)) u_dut8 (
        .CLK(CLK), .RST_N(RST_N), .bus(b8.slave));
    cache_line_bank #(.DATA_WIDTH(32), .WORDS_PER_LINE(4), .LINE_ADDR_WIDTH(11)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .bus(b4.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_do"},    b8.DO,        0);
        chk({tag, "_off"},   b8.DO_OFFSET, 0);
        chk({tag, "_vld"},   b8.DO_VALID,  0);
        chk({tag, "_last"},  b8.DO_LAST,   0);
        chk({tag, "_ready"}, b8.READY,     1);
    endtask

    task automatic wr1(input logic [13:0] addr, input logic [7:0] data);
        b8.REQ = 1'b1; b8.WE = 1'b1; b8.BURST = 1'b0; b8.ADDR = addr; b8.DI = data;
        cyc();
        b8.REQ = 1'b0; b8.WE = 1'b0;
        chk("wr1_ready", b8.READY, 1);
    endtask

    task automatic rd1(input logic [13:0] addr, input logic [7:0] exp);
        b8.DO_READY = 1'b1;
        b8.REQ = 1'b1; b8.WE = 1'b0; b8.BURST = 1'b0; b8.ADDR = addr;
        cyc();
        b8.REQ = 1'b0;
        chk("rd1_ready_busy", b8.READY, 0);
        chk("rd1_vld_early",  b8.DO_VALID, 0);
        cyc();
        chk("rd1_do",   b8.DO, exp);
        chk("rd1_off",  b8.DO_OFFSET, addr[2:0]);
        chk("rd1_vld",  b8.DO_VALID, 1);
        chk("rd1_last", b8.DO_LAST, 1);
        cyc();
        chk("rd1_vld_end",   b8.DO_VALID, 0);
        chk("rd1_ready_end", b8.READY, 1);
    endtask

    // Fill from addr with base+k on beat k; nbeats < 8 leaves the fill open.
    // gap_at inserts one REQ-low cycle before that beat (0 = none).
    task automatic fill8(input logic [13:0] addr, input logic [7:0] base,
                         input int nbeats, input int gap_at);
        b8.REQ = 1'b1; b8.WE = 1'b1; b8.BURST = 1'b1; b8.ADDR = addr; b8.DI = base;
        cyc();
        for (int k = 1; k < nbeats; k++) begin
            if (k == gap_at) begin
                b8.REQ = 1'b0; b8.DI = 8'hFF;
                cyc();
                chk("fill_gap_ready", b8.READY, 1);
            end
            // WE/BURST/ADDR deliberately scrambled: they must be ignored.
            b8.REQ = 1'b1; b8.WE = k[0]; b8.BURST = 1'b0; b8.ADDR = 14'h3FFF;
            b8.DI = base + 8'(k);
            cyc();
            chk("fill_ready", b8.READY, 1);
        end
        b8.REQ = 1'b0; b8.WE = 1'b0; b8.BURST = 1'b0;
    endtask

    // Burst read; word i expected base+i at offset addr+i (data checked for i<nchk).
    // pat gives DO_READY per cycle, MSB first, repeating. poke drives a write
    // request throughout the stream, which must be ignored.
    task automatic burst8(input logic [13:0] addr, input logic [7:0] base, input int nchk,
                          input logic [3:0] pat, input bit poke);
        int         j;
        int         guard;
        logic       p;
        logic [2:0] eo;
        j = 0;
        b8.REQ = 1'b1; b8.WE = 1'b0; b8.BURST = 1'b1; b8.ADDR = addr;
        cyc();
        b8.REQ = 1'b0;
        chk("brd_ready_read", b8.READY, 0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            guard = 0;
            eo = addr[2:0] + 3'(i);
            while (1) begin
                p = pat[3 - (j % 4)];
                j++;
                b8.DO_READY = p;
                if (poke) begin
                    b8.REQ = 1'b1; b8.WE = 1'b1; b8.BURST = 1'b0; b8.ADDR = addr; b8.DI = 8'hEE;
                end
                if (i < nchk) chk("brd_do", b8.DO, base + 8'(i));
                chk("brd_off",   b8.DO_OFFSET, eo);
                chk("brd_vld",   b8.DO_VALID, 1);
                chk("brd_last",  b8.DO_LAST, (i == 7));
                chk("brd_ready", b8.READY, 0);
                cyc();
                if (p) break;
                guard++;
                if (guard > 16) begin
                    n_err++;
                    $display("FAIL brd_timeout: word %0d never accepted", i);
                    break;
                end
            end
        end
        b8.REQ = 1'b0; b8.WE = 1'b0; b8.DO_READY = 1'b1;
        chk("brd_vld_end",   b8.DO_VALID, 0);
        chk("brd_last_end",  b8.DO_LAST, 0);
        chk("brd_ready_end", b8.READY, 1);
    endtask

    initial begin
        b8.REQ = 0; b8.WE = 0; b8.BURST = 0; b8.ADDR = '0; b8.DI = '0; b8.DO_READY = 1;
        b4.REQ = 0; b4.WE = 0; b4.BURST = 0; b4.ADDR = '0; b4.DI = '0; b4.DO_READY = 1;
        RST_N = 1'b0;
        cyc();
        cyc();
        chk_rst_outputs("rst");
        chk("rst_ready4", b4.READY, 1);
        RST_N = 1'b1;
        cyc();

        // Single write/read, back-to-back writes.
        wr1(14'h01D, 8'hA5);
        wr1(14'h01E, 8'h3C);
        rd1(14'h01D, 8'hA5);
        rd1(14'h01E, 8'h3C);

        // Line fill at line 3 offset 5 with a gap, then burst reads.
        fill8(14'h01D, 8'h10, 8, 4);
        chk("fill_done_ready", b8.READY, 1);
        burst8(14'h01D, 8'h10, 8, 4'b1111, 1'b0);
        burst8(14'h01D, 8'h10, 8, 4'b1001, 1'b0);

        // Write request during STREAM must not touch the RAM.
        burst8(14'h01D, 8'h10, 8, 4'b1001, 1'b1);
        burst8(14'h01D, 8'h10, 8, 4'b1111, 1'b0);
        rd1(14'h01D, 8'h10);

        // Reset in the middle of a burst.
        b8.REQ = 1'b1; b8.WE = 1'b0; b8.BURST = 1'b1; b8.ADDR = 14'h01D;
        cyc();
        b8.REQ = 1'b0;
        cyc();
        cyc();
        chk("mid_burst_vld", b8.DO_VALID, 1);
        chk("mid_burst_off", b8.DO_OFFSET, 6);
        RST_N = 1'b0;
        #1;
        chk_rst_outputs("rst_burst");
        cyc();
        RST_N = 1'b1;
        cyc();
        rd1(14'h01D, 8'h10);

        // Reset after 3 fill beats at line 5 offset 2.
        fill8(14'h02A, 8'h50, 3, 0);
        RST_N = 1'b0;
        #1;
        chk_rst_outputs("rst_fill");
        cyc();
        RST_N = 1'b1;
        cyc();
        burst8(14'h02A, 8'h50, 3, 4'b1111, 1'b0);

        // 4 x 32-bit configuration: fill line 2 from offset 3, burst back.
        b4.REQ = 1'b1; b4.WE = 1'b1; b4.BURST = 1'b1; b4.ADDR = 13'h00B; b4.DI = 32'hDEAD_0000;
        cyc();
        for (int k = 1; k < 4; k++) begin
            b4.WE = 1'b0; b4.ADDR = 13'h1FFF; b4.DI = 32'hDEAD_0000 + 32'(k);
            cyc();
            chk("w4_fill_ready", b4.READY, 1);
        end
        b4.REQ = 1'b1; b4.WE = 1'b0; b4.BURST = 1'b1; b4.ADDR = 13'h00B;
        cyc();
        b4.REQ = 1'b0;
        chk("w4_ready_read", b4.READY, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] eo4;
            eo4 = 2'd3 + 2'(i);
            chk("w4_do",   b4.DO, 32'hDEAD_0000 + 32'(i));
            chk("w4_off",  b4.DO_OFFSET, eo4);
            chk("w4_vld",  b4.DO_VALID, 1);
            chk("w4_last", b4.DO_LAST, (i == 3));
            cyc();
        end
        chk("w4_vld_end",   b4.DO_VALID, 0);
        chk("w4_ready_end", b4.READY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
